// File: rtl/cam_testmode_wr_if.sv
// Register-write request channel between the test-mode writer and the shared SCCB master.
// valid/ready: a write transfers on a cycle where wr_valid & wr_ready; addr/data hold until then.
interface cam_testmode_wr_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_done;

    modport master (output wr_valid, output wr_addr, output wr_data,
                    input  wr_ready, input  wr_done);
    modport slave  (input  wr_valid, input  wr_addr, input  wr_data,
                    output wr_ready, output wr_done);
endinterface

// File: rtl/cam_testmode_wr.sv
// Converts the requested test_mode level into two OV7670 scaling-register writes
// (0x70, 0x71 bit7 = colour bar) and reports the mode once a frame has settled.
module cam_testmode_wr #(
    parameter logic [7:0]  C_XSC_BASE = 8'h3A,
    parameter logic [7:0]  C_YSC_BASE = 8'h35,
    parameter int unsigned C_TIMEOUT  = 250_000,
    parameter int unsigned C_SETTLE   = 1_000_000
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     init_done,
    input  logic                     test_mode,
    cam_testmode_wr_if.master        bus,
    output logic                     busy,
    output logic                     mode_applied,
    output logic                     err,
    output logic [2:0]               dbg_state
);

    localparam int unsigned C_MAX = (C_TIMEOUT > C_SETTLE) ? C_TIMEOUT : C_SETTLE;
    localparam int unsigned TW    = (C_MAX > 1) ? $clog2(C_MAX) : 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(C_TIMEOUT - 1);
    localparam logic [TW-1:0] SET_LAST = TW'(C_SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_X   = 3'd1,
        S_WAIT_X = 3'd2,
        S_WR_Y   = 3'd3,
        S_WAIT_Y = 3'd4,
        S_SETTLE = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic           tgt_q, tgt_d;
    logic           mode_q, mode_d;
    logic           err_q, err_d;
    logic [TW-1:0]  timer_q, timer_d;

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        mode_d  = mode_q;
        err_d   = err_q;
        timer_d = timer_q;
        if (state_q == S_WAIT_X || state_q == S_WAIT_Y || state_q == S_SETTLE)
            timer_d = timer_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (init_done && (test_mode != mode_q)) begin
                    tgt_d   = test_mode;
                    state_d = S_WR_X;
                end
            end
            S_WR_X: if (bus.wr_ready) state_d = S_WAIT_X;
            S_WAIT_X: begin
                // A done pulse on the last timeout cycle still counts as success.
                if (bus.wr_done) begin
                    state_d = S_WR_Y;
                end else if (timer_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WR_Y: if (bus.wr_ready) state_d = S_WAIT_Y;
            S_WAIT_Y: begin
                if (bus.wr_done) begin
                    state_d = S_SETTLE;
                end else if (timer_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (timer_q == SET_LAST) begin
                    mode_d  = tgt_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q)
            timer_d = '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            tgt_q   <= 1'b0;
            mode_q  <= 1'b0;
            err_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            timer_q <= timer_d;
        end
    end

    // Request fields decode straight from state, so reset clears them without a clock.
    always_comb begin
        bus.wr_valid = 1'b0;
        bus.wr_addr  = 8'h00;
        bus.wr_data  = 8'h00;
        case (state_q)
            S_WR_X: begin
                bus.wr_valid = 1'b1;
                bus.wr_addr  = 8'h70;
                bus.wr_data  = C_XSC_BASE & 8'h7F;
            end
            S_WR_Y: begin
                bus.wr_valid = 1'b1;
                bus.wr_addr  = 8'h71;
                bus.wr_data  = {tgt_q, C_YSC_BASE[6:0]};
            end
            default: ;
        endcase
    end

    assign busy         = (state_q != S_IDLE);
    assign mode_applied = mode_q;
    assign err          = err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_cam_testmode_wr.sv
// Directed bench for cam_testmode_wr: a scripted SCCB slave answers requests while a
// queue of expected {addr,data} writes is checked at every handshake.
module tb_cam_testmode_wr;

    localparam int unsigned TO  = 20;
    localparam int unsigned SET = 8;

    logic       clk;
    logic       rstn;
    logic       init_done;
    logic       test_mode;
    logic       busy;
    logic       mode_applied;
    logic       err;
    logic [2:0] dbg_state;
    int         cyc;
    int         errors;
    int         checks;
    int         t0;
    int         t1;
    int         n;
    logic       flag;
    logic [15:0] exp_q[$];

    cam_testmode_wr_if bus ();

    cam_testmode_wr #(
        .C_XSC_BASE (8'h3A),
        .C_YSC_BASE (8'h35),
        .C_TIMEOUT  (TO),
        .C_SETTLE   (SET)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .init_done    (init_done),
        .test_mode    (test_mode),
        .bus          (bus),
        .busy         (busy),
        .mode_applied (mode_applied),
        .err          (err),
        .dbg_state    (dbg_state)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_seq(input logic tgt);
        exp_q.push_back({8'h70, 8'h3A});
        exp_q.push_back({8'h71, tgt, 7'h35});
    endtask

    // Waits for a request, optionally stalls wr_ready, accepts it, ends in first WAIT cycle.
    task automatic accept_write(input int ready_dly, input string tag, output int start_cyc);
        int          w;
        logic [7:0]  a0;
        logic [7:0]  d0;
        logic        stable;
        logic [15:0] exp;
        w = 0;
        while (bus.wr_valid !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check(32'(bus.wr_valid), 32'd1, {tag, "_valid"});
        start_cyc = cyc;
        a0 = bus.wr_addr;
        d0 = bus.wr_data;
        stable = 1'b1;
        for (int i = 0; i < ready_dly; i++) begin
            @(negedge clk);
            if (bus.wr_addr !== a0 || bus.wr_data !== d0 || bus.wr_valid !== 1'b1)
                stable = 1'b0;
        end
        if (ready_dly > 0) check(32'(stable), 32'd1, {tag, "_stable"});
        check(32'(exp_q.size() != 0), 32'd1, {tag, "_expected"});
        exp = 16'hFFFF;
        if (exp_q.size() != 0) exp = exp_q.pop_front();
        check(32'({bus.wr_addr, bus.wr_data}), 32'(exp), {tag, "_addrdata"});
        bus.wr_ready = 1'b1;
        @(negedge clk);
        bus.wr_ready = 1'b0;
        check(32'(bus.wr_valid), 32'd0, {tag, "_drop"});
    endtask

    // Called in WAIT cycle 1: raises wr_done during WAIT cycle k.
    task automatic finish_write(input int k);
        repeat (k - 1) @(negedge clk);
        bus.wr_done = 1'b1;
        @(negedge clk);
        bus.wr_done = 1'b0;
    endtask

    task automatic wait_mode(input logic exp, input string tag, output int at_cyc);
        int w;
        w = 0;
        while (mode_applied !== exp && w < 200) begin
            @(negedge clk);
            w++;
        end
        check(32'(mode_applied), 32'(exp), tag);
        at_cyc = cyc;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rstn = 1'b0;
        init_done = 1'b0;
        test_mode = 1'b0;
        bus.wr_ready = 1'b0;
        bus.wr_done = 1'b0;
        repeat (2) @(negedge clk);
        check(32'(bus.wr_valid), 32'd0, "rst_valid");
        check(32'(bus.wr_addr), 32'd0, "rst_addr");
        check(32'(bus.wr_data), 32'd0, "rst_data");
        check(32'(busy), 32'd0, "rst_busy");
        check(32'(mode_applied), 32'd0, "rst_mode");
        check(32'(err), 32'd0, "rst_err");
        rstn = 1'b1;

        // 1: no activity before init_done, then first sequence to colour bar
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            test_mode = (i % 3 != 1);
            if (bus.wr_valid !== 1'b0 || busy !== 1'b0) flag = 1'b1;
        end
        check(32'(flag), 32'd0, "s1_no_init_quiet");
        test_mode = 1'b1;
        push_seq(1'b1);
        init_done = 1'b1;
        accept_write(0, "s1_x", t0);
        finish_write(3);
        accept_write(0, "s1_y", n);
        finish_write(3);
        wait_mode(1'b1, "s1_mode", t1);
        check(32'(t1 - t0), 32'(2 * (3 + 1) + SET), "s1_latency");

        // 2: back to normal with stalled ready
        @(negedge clk);
        test_mode = 1'b0;
        push_seq(1'b0);
        accept_write(5, "s2_x", n);
        finish_write(2);
        accept_write(3, "s2_y", n);
        finish_write(2);
        wait_mode(1'b0, "s2_mode", n);

        // 3a: double toggle in WAIT_X -> single sequence
        @(negedge clk);
        test_mode = 1'b1;
        push_seq(1'b1);
        accept_write(0, "s3a_x", n);
        test_mode = 1'b0;
        @(negedge clk);
        test_mode = 1'b1;
        finish_write(4);
        accept_write(0, "s3a_y", n);
        finish_write(2);
        wait_mode(1'b1, "s3a_mode", n);
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) flag = 1'b1;
        end
        check(32'(flag), 32'd0, "s3a_no_extra_seq");
        check(32'(exp_q.size()), 32'd0, "s3a_queue_empty");

        // 3b: single toggle in WAIT_Y -> completes with old target, then re-runs
        test_mode = 1'b0;
        push_seq(1'b0);
        accept_write(0, "s3b_x", n);
        finish_write(2);
        accept_write(0, "s3b_y", n);
        test_mode = 1'b1;
        push_seq(1'b1);
        finish_write(2);
        wait_mode(1'b0, "s3b_mode_old", n);
        accept_write(0, "s3b_x2", n);
        finish_write(2);
        accept_write(0, "s3b_y2", n);
        finish_write(2);
        wait_mode(1'b1, "s3b_mode_new", n);

        // 4: withheld wr_done in WAIT_Y -> timeout, retry
        @(negedge clk);
        test_mode = 1'b0;
        push_seq(1'b0);
        accept_write(0, "s4_x", n);
        finish_write(2);
        accept_write(0, "s4_y", n);
        n = 1;
        while (err !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(32'(n - 1), 32'(TO), "s4_timeout_cycles");
        check(32'(busy), 32'd0, "s4_idle_after_timeout");
        check(32'(mode_applied), 32'd1, "s4_mode_kept");
        push_seq(1'b0);
        accept_write(0, "s4_rx", n);
        finish_write(2);
        accept_write(0, "s4_ry", n);
        finish_write(2);
        wait_mode(1'b0, "s4_mode", n);
        check(32'(err), 32'd1, "s4_err_sticky");

        // 5: asynchronous reset while WR_Y is requesting
        @(negedge clk);
        test_mode = 1'b1;
        push_seq(1'b1);
        accept_write(0, "s5_x", n);
        finish_write(2);
        check(32'(bus.wr_valid), 32'd1, "s5_in_wr_y");
        rstn = 1'b0;
        #1;
        check(32'(bus.wr_valid), 32'd0, "s5_async_valid");
        check(32'(bus.wr_addr), 32'd0, "s5_async_addr");
        check(32'(bus.wr_data), 32'd0, "s5_async_data");
        check(32'(busy), 32'd0, "s5_async_busy");
        check(32'(err), 32'd0, "s5_async_err");
        check(32'(dbg_state), 32'd0, "s5_async_state");
        exp_q.delete();
        init_done = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check(32'(busy), 32'd0, "s5_hold_no_init");
        push_seq(1'b1);
        init_done = 1'b1;
        accept_write(0, "s5_rx", n);
        finish_write(2);
        accept_write(0, "s5_ry", n);
        finish_write(2);
        wait_mode(1'b1, "s5_mode", n);

        // 6a: stray wr_done while IDLE
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.wr_done = 1'b1;
            @(negedge clk);
            bus.wr_done = 1'b0;
        end
        check(32'(dbg_state), 32'd0, "s6_idle_stray");

        // 6b: stray wr_done while SETTLE must not shorten it
        test_mode = 1'b0;
        push_seq(1'b0);
        accept_write(0, "s6_x", t0);
        finish_write(2);
        accept_write(0, "s6_y", n);
        finish_write(2);
        for (int i = 0; i < 2; i++) begin
            bus.wr_done = 1'b1;
            @(negedge clk);
            bus.wr_done = 1'b0;
            @(negedge clk);
        end
        check(32'(dbg_state), 32'd5, "s6_settle_stray");
        wait_mode(1'b0, "s6_mode", t1);
        check(32'(t1 - t0), 32'(2 * (2 + 1) + SET), "s6_latency");

        // 6c: wr_done on the timeout cycle wins
        @(negedge clk);
        test_mode = 1'b1;
        push_seq(1'b1);
        accept_write(0, "s6c_x", n);
        finish_write(int'(TO));
        check(32'(err), 32'd0, "s6c_no_err");
        accept_write(0, "s6c_y", n);
        finish_write(2);
        wait_mode(1'b1, "s6c_mode", n);
        check(32'(err), 32'd0, "s6c_err_final");
        check(32'(exp_q.size()), 32'd0, "final_queue_empty");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
